// File: rtl/note_pkg.sv
// note_pkg: shared screen constants, slot record and lane geometry helper.
package note_pkg;
  localparam int DEF_N_LANES = 3;
  localparam int DEF_SLOTS = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_BORDER = 4;
  localparam int DEF_LANE_W = 208;
  localparam int DEF_GAP = 4;
  localparam int DEF_NOTE_H = 40;
  localparam int DEF_STRIKE_Y = 380;
  localparam int DEF_HIT_TOL = 16;
  localparam int STRIKE_H = 4;
  localparam logic [71:0] DEF_LANE_COLORS = 72'h0000FF_FFFF00_FF0000;
  typedef struct packed {
    logic       valid;
    logic [9:0] y;
  } slot_t;
  function automatic logic [10:0] lane_x0(input int i, input int border, input int lane_w, input int gap);
    return 11'(border + i * (lane_w + gap));
  endfunction
endpackage

// File: rtl/lane_note_renderer_if.sv
// lane_note_renderer_if: spawn handshake between the note spawner and the renderer.
interface lane_note_renderer_if #(
  parameter int N_LANES = 3,
  localparam int LW = N_LANES > 1 ? $clog2(N_LANES) : 1
);
  logic          spawn_valid;
  logic [LW-1:0] spawn_lane;
  logic          spawn_ready;
  modport master (output spawn_valid, spawn_lane, input spawn_ready);
  modport slave (input spawn_valid, spawn_lane, output spawn_ready);
endinterface

// File: rtl/lane_slots.sv
// lane_slots: note slots of one lane with spawn, movement, retire, hit search and pixel test.
module lane_slots
  import note_pkg::*;
#(
  parameter int SLOTS = DEF_SLOTS,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int NOTE_H = DEF_NOTE_H,
  parameter int STRIKE_Y = DEF_STRIKE_Y,
  parameter int HIT_TOL = DEF_HIT_TOL,
  parameter int LANE_W = DEF_LANE_W,
  parameter logic [10:0] X0 = 11'(DEF_BORDER),
  localparam int CW = $clog2(SLOTS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          frame_tick,
  input  logic [3:0]    speed,
  input  logic          spawn,
  input  logic          press,
  input  logic [9:0]    h_count,
  input  logic [9:0]    v_count,
  output logic          free_any,
  output logic          hit,
  output logic [CW-1:0] retire_cnt,
  output logic          note_pixel
);
  localparam logic [10:0] VA = 11'(V_ACTIVE);
  localparam logic [10:0] NH = 11'(NOTE_H);
  localparam logic [10:0] WIN_LO = 11'(STRIKE_Y - HIT_TOL);
  localparam logic [10:0] WIN_HI = 11'(STRIKE_Y + HIT_TOL);
  localparam logic [10:0] XE = X0 + 11'(LANE_W);
  slot_t slots [SLOTS];
  slot_t nxt [SLOTS];
  int free_idx, best;
  logic found;
  logic [9:0] best_y;
  logic [10:0] ny, bot, top, hh, vv;
  always_comb begin
    free_any = 1'b0;
    free_idx = 0;
    found = 1'b0;
    best = 0;
    best_y = '0;
    retire_cnt = '0;
    note_pixel = 1'b0;
    ny = '0;
    bot = '0;
    top = '0;
    hh = {1'b0, h_count};
    vv = {1'b0, v_count};
    for (int s = SLOTS - 1; s >= 0; s--)
      if (!slots[s].valid) begin
        free_any = 1'b1;
        free_idx = s;
      end
    // strict '>' keeps the lowest index among equal-y candidates
    for (int s = 0; s < SLOTS; s++) begin
      top = {1'b0, slots[s].y};
      bot = top + NH;
      if (slots[s].valid && bot >= WIN_LO && bot <= WIN_HI && (!found || slots[s].y > best_y)) begin
        found = 1'b1;
        best = s;
        best_y = slots[s].y;
      end
      if (slots[s].valid && hh >= X0 && hh < XE && vv >= top && vv < bot) note_pixel = 1'b1;
    end
    hit = press && found;
    for (int s = 0; s < SLOTS; s++) begin
      nxt[s] = slots[s];
      ny = {1'b0, slots[s].y} + 11'(speed);
      if (hit && best == s) nxt[s].valid = 1'b0;
      else if (frame_tick && run && slots[s].valid) begin
        if (ny >= VA) begin
          nxt[s].valid = 1'b0;
          retire_cnt = retire_cnt + CW'(1);
        end else nxt[s].y = ny[9:0];
      end else if (spawn && free_idx == s) nxt[s] = '{valid: 1'b1, y: 10'd0};
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) slots <= '{default: '0};
    else slots <= nxt;
endmodule

// File: rtl/lane_note_renderer.sv
// lane_note_renderer: N-lane falling-note playfield with spawn demux, scoring and pixel rendering.
module lane_note_renderer
  import note_pkg::*;
#(
  parameter int N_LANES = DEF_N_LANES,
  parameter int SLOTS = DEF_SLOTS,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int BORDER = DEF_BORDER,
  parameter int LANE_W = DEF_LANE_W,
  parameter int GAP = DEF_GAP,
  parameter int NOTE_H = DEF_NOTE_H,
  parameter int STRIKE_Y = DEF_STRIKE_Y,
  parameter int HIT_TOL = DEF_HIT_TOL,
  parameter logic [24*N_LANES-1:0] LANE_COLORS = DEF_LANE_COLORS[24*N_LANES-1:0]
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 frame_tick,
  input  logic [3:0]           speed,
  input  logic [9:0]           h_count,
  input  logic [9:0]           v_count,
  lane_note_renderer_if.slave  sp,
  input  logic [N_LANES-1:0]   btn,
  output logic                 hit_pulse,
  output logic                 miss_pulse,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count,
  output logic [23:0]          rgb
);
  localparam int LW = N_LANES > 1 ? $clog2(N_LANES) : 1;
  localparam int CW = $clog2(SLOTS + 1);
  localparam logic [10:0] HA = 11'(H_ACTIVE);
  localparam logic [10:0] VA = 11'(V_ACTIVE);
  localparam logic [10:0] SY0 = 11'(STRIKE_Y);
  localparam logic [10:0] SY1 = 11'(STRIKE_Y + STRIKE_H);
  logic [N_LANES-1:0] btn_q, press, free_any, hit, note_pix;
  logic [CW-1:0] retire [N_LANES];
  logic [2**LW-1:0] free_pad;
  logic fire, nf, in_lane;
  logic [7:0] n_hit, n_miss;
  logic [16:0] hit_sum, miss_sum;
  logic [23:0] ncol, rgb_d;
  logic [10:0] hh, vv, x0;
  assign press = btn & ~btn_q & {N_LANES{run}};
  assign sp.spawn_ready = run && free_pad[sp.spawn_lane];
  assign fire = sp.spawn_valid && sp.spawn_ready;
  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    lane_slots #(
      .SLOTS(SLOTS), .V_ACTIVE(V_ACTIVE), .NOTE_H(NOTE_H), .STRIKE_Y(STRIKE_Y),
      .HIT_TOL(HIT_TOL), .LANE_W(LANE_W), .X0(lane_x0(i, BORDER, LANE_W, GAP))
    ) u_lane (
      .clk(clk), .rst(rst), .run(run), .frame_tick(frame_tick), .speed(speed),
      .spawn(fire && sp.spawn_lane == LW'(i)), .press(press[i]),
      .h_count(h_count), .v_count(v_count), .free_any(free_any[i]), .hit(hit[i]),
      .retire_cnt(retire[i]), .note_pixel(note_pix[i])
    );
  end
  always_comb begin
    free_pad = '0;
    free_pad[N_LANES-1:0] = free_any;
    n_hit = '0;
    n_miss = '0;
    for (int i = 0; i < N_LANES; i++) begin
      n_hit = n_hit + 8'(hit[i]);
      n_miss = n_miss + 8'(retire[i]) + 8'(press[i] & ~hit[i]);
    end
    hit_sum = 17'(hit_count) + 17'(n_hit);
    miss_sum = 17'(miss_count) + 17'(n_miss);
  end
  always_comb begin
    hh = {1'b0, h_count};
    vv = {1'b0, v_count};
    nf = 1'b0;
    ncol = '0;
    in_lane = 1'b0;
    x0 = '0;
    for (int i = N_LANES - 1; i >= 0; i--) begin
      x0 = lane_x0(i, BORDER, LANE_W, GAP);
      if (hh >= x0 && hh < x0 + 11'(LANE_W)) in_lane = 1'b1;
      if (note_pix[i]) begin
        nf = 1'b1;
        ncol = LANE_COLORS[24*i +: 24];
      end
    end
    rgb_d = (hh >= HA || vv >= VA) ? 24'h0 : nf ? ncol : (vv >= SY0 && vv < SY1) ? 24'h0 : in_lane ? 24'hFFFFFF : 24'h0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      btn_q <= '0;
      hit_pulse <= 1'b0;
      miss_pulse <= 1'b0;
      hit_count <= '0;
      miss_count <= '0;
      rgb <= '0;
    end else begin
      btn_q <= btn;
      hit_pulse <= |hit;
      miss_pulse <= n_miss != 8'd0;
      hit_count <= hit_sum[16] ? 16'hFFFF : hit_sum[15:0];
      miss_count <= miss_sum[16] ? 16'hFFFF : miss_sum[15:0];
      rgb <= rgb_d;
    end
endmodule

// File: tb/tb_lane_note_renderer.sv
// tb_lane_note_renderer: directed sequences, pixel table and randomized model comparison.
module tb_lane_note_renderer;
  localparam int NL = 3, NS = 4;
  logic clk = 0, rst = 1, run = 0, frame_tick = 0;
  logic [3:0] speed = 0;
  logic [9:0] h_count = 0, v_count = 0;
  logic [NL-1:0] btn = 0;
  logic hit_pulse, miss_pulse;
  logic [15:0] hit_count, miss_count;
  logic [23:0] rgb;
  int n_cmp = 0, n_bad = 0;
  lane_note_renderer_if #(.N_LANES(NL)) sp_if ();
  lane_note_renderer dut (
    .clk(clk), .rst(rst), .run(run), .frame_tick(frame_tick), .speed(speed),
    .h_count(h_count), .v_count(v_count), .sp(sp_if), .btn(btn),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .hit_count(hit_count),
    .miss_count(miss_count), .rgb(rgb)
  );
  always #5 clk = ~clk;
  typedef struct {
    int h;
    int v;
    logic [23:0] exp;
  } pix_vec_t;
  pix_vec_t pv [14];
  bit mv [NL][NS];
  int my [NL][NS];
  bit bprev [NL];
  int mhc, mmc, sl, sidx, nh, nm, b, p;
  bit rdy, e_hp, e_mp;
  logic [23:0] e_rgb;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1; run = 0; frame_tick = 0; btn = 0; speed = 0; sp_if.spawn_valid = 0;
    cyc(); cyc();
    rst = 0;
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      frame_tick = 1;
      cyc();
    end
    frame_tick = 0;
  endtask
  task automatic spawn(input int lane);
    sp_if.spawn_lane = 2'(lane);
    sp_if.spawn_valid = 1;
    cyc();
    sp_if.spawn_valid = 0;
  endtask
  function automatic logic [23:0] lane_col(input int l);
    return l == 0 ? 24'hFF0000 : l == 1 ? 24'hFFFF00 : 24'h0000FF;
  endfunction
  function automatic logic [23:0] ref_pix(input int h, input int v);
    if (h >= 640 || v >= 480) return 24'h0;
    for (int l = 0; l < NL; l++)
      for (int s = 0; s < NS; s++)
        if (mv[l][s] && h >= 4 + l * 212 && h < 212 + l * 212 && v >= my[l][s] && v < my[l][s] + 40) return lane_col(l);
    if (v >= 380 && v < 384) return 24'h0;
    for (int l = 0; l < NL; l++) if (h >= 4 + l * 212 && h < 212 + l * 212) return 24'hFFFFFF;
    return 24'h0;
  endfunction
  initial begin
    pv[0] = '{4, 100, 24'hFF0000};    pv[1] = '{212, 100, 24'h000000};
    pv[2] = '{100, 381, 24'h000000};  pv[3] = '{700, 100, 24'h000000};
    pv[4] = '{211, 139, 24'hFF0000};  pv[5] = '{100, 140, 24'hFFFFFF};
    pv[6] = '{100, 99, 24'hFFFFFF};   pv[7] = '{3, 120, 24'h000000};
    pv[8] = '{216, 120, 24'hFFFFFF};  pv[9] = '{635, 10, 24'hFFFFFF};
    pv[10] = '{636, 10, 24'h000000};  pv[11] = '{100, 379, 24'hFFFFFF};
    pv[12] = '{100, 384, 24'hFFFFFF}; pv[13] = '{300, 480, 24'h000000};
    sp_if.spawn_valid = 0;
    sp_if.spawn_lane = 0;
    do_reset();
    chk("reset_rgb", rgb, 0);
    chk("reset_hit_count", hit_count, 0);
    chk("reset_miss_count", miss_count, 0);
    chk("reset_pulses", {hit_pulse, miss_pulse}, 0);
    sp_if.spawn_lane = 1; #1;
    chk("ready_when_stopped", sp_if.spawn_ready, 0);
    // hit a note sitting exactly at the strike line
    run = 1; #1;
    chk("s1_ready", sp_if.spawn_ready, 1);
    spawn(1);
    speed = 4;
    tick(85);
    btn[1] = 1;
    cyc();
    chk("s1_hit_pulse", hit_pulse, 1);
    chk("s1_hit_count", hit_count, 1);
    chk("s1_no_miss", miss_pulse, 0);
    cyc();
    chk("s1_hit_pulse_drop", hit_pulse, 0);
    h_count = 300; v_count = 350;
    cyc();
    chk("s1_slot_freed_pix", rgb, 24'hFFFFFF);
    // lane 0 full
    do_reset();
    run = 1;
    for (int i = 0; i < 4; i++) spawn(0);
    sp_if.spawn_lane = 0; #1;
    chk("s2_lane0_full", sp_if.spawn_ready, 0);
    sp_if.spawn_lane = 1; #1;
    chk("s2_lane1_ready", sp_if.spawn_ready, 1);
    sp_if.spawn_lane = 2; #1;
    chk("s2_lane2_ready", sp_if.spawn_ready, 1);
    sp_if.spawn_lane = 3; #1;
    chk("s2_lane3_invalid", sp_if.spawn_ready, 0);
    spawn(0);
    sp_if.spawn_lane = 0; #1;
    chk("s2_still_full", sp_if.spawn_ready, 0);
    // unpressed note retires off the bottom
    do_reset();
    run = 1;
    spawn(0);
    speed = 15;
    tick(31);
    chk("s3_no_miss_yet", miss_count, 0);
    tick(1);
    chk("s3_miss_pulse", miss_pulse, 1);
    chk("s3_miss_count", miss_count, 1);
    cyc();
    chk("s3_miss_pulse_drop", miss_pulse, 0);
    // empty press and held button
    do_reset();
    run = 1;
    btn = 3'b100;
    cyc();
    chk("s4_empty_miss", miss_pulse, 1);
    chk("s4_miss_count", miss_count, 1);
    chk("s4_no_hit", hit_pulse, 0);
    p = 0;
    repeat (100) begin
      cyc();
      if (miss_pulse || hit_pulse) p++;
    end
    chk("s4_hold_pulses", p, 0);
    btn = 0; cyc();
    run = 0; btn = 3'b001; cyc();
    run = 1; cyc(); cyc();
    chk("s4_frozen_press", miss_count, 1);
    // hit and frame tick together
    do_reset();
    run = 1;
    spawn(0);
    speed = 4;
    tick(85);
    btn[0] = 1; frame_tick = 1;
    cyc();
    frame_tick = 0;
    chk("s5_hit_pulse", hit_pulse, 1);
    chk("s5_no_miss", miss_pulse, 0);
    chk("s5_hit_count", hit_count, 1);
    tick(40);
    chk("s5_no_retire", miss_count, 0);
    // pixel table with a lane 0 note at y=100
    do_reset();
    run = 1;
    spawn(0);
    speed = 4;
    tick(25);
    speed = 0;
    foreach (pv[i]) begin
      h_count = 10'(pv[i].h); v_count = 10'(pv[i].v);
      cyc();
      chk($sformatf("pix_%0d_%0d", pv[i].h, pv[i].v), rgb, pv[i].exp);
    end
    // randomized run against the reference model
    do_reset();
    foreach (mv[l, s]) begin mv[l][s] = 0; my[l][s] = 0; end
    foreach (bprev[l]) bprev[l] = 0;
    mhc = 0; mmc = 0;
    for (int c = 0; c < 3000; c++) begin
      run = $urandom_range(0, 9) != 0;
      frame_tick = $urandom_range(0, 3) == 0;
      speed = 4'($urandom_range(0, 15));
      for (int l = 0; l < NL; l++) if ($urandom_range(0, 3) == 0) btn[l] = ~btn[l];
      sp_if.spawn_valid = $urandom_range(0, 2) == 0;
      sp_if.spawn_lane = 2'($urandom_range(0, 3));
      h_count = 10'($urandom_range(0, 699));
      v_count = 10'($urandom_range(0, 499));
      #1;
      sl = int'(sp_if.spawn_lane); rdy = 0; sidx = 0;
      if (run && sl < NL) for (int s = NS - 1; s >= 0; s--) if (!mv[sl][s]) begin rdy = 1; sidx = s; end
      chk("rnd_ready", sp_if.spawn_ready, rdy);
      e_rgb = ref_pix(int'(h_count), int'(v_count));
      nh = 0; nm = 0;
      for (int l = 0; l < NL; l++) begin
        if (run && btn[l] && !bprev[l]) begin
          b = -1;
          for (int s = 0; s < NS; s++)
            if (mv[l][s] && my[l][s] + 40 >= 364 && my[l][s] + 40 <= 396 && (b < 0 || my[l][s] > my[l][b])) b = s;
          if (b >= 0) begin mv[l][b] = 0; nh++; end else nm++;
        end
        bprev[l] = btn[l];
        if (frame_tick && run)
          for (int s = 0; s < NS; s++)
            if (mv[l][s]) begin
              if (my[l][s] + int'(speed) >= 480) begin mv[l][s] = 0; nm++; end
              else my[l][s] += int'(speed);
            end
      end
      if (sp_if.spawn_valid && rdy) begin mv[sl][sidx] = 1; my[sl][sidx] = 0; end
      mhc = mhc + nh > 65535 ? 65535 : mhc + nh;
      mmc = mmc + nm > 65535 ? 65535 : mmc + nm;
      e_hp = nh > 0; e_mp = nm > 0;
      cyc();
      chk("rnd_rgb", rgb, e_rgb);
      chk("rnd_hit_pulse", hit_pulse, e_hp);
      chk("rnd_miss_pulse", miss_pulse, e_mp);
      chk("rnd_hit_count", hit_count, mhc);
      chk("rnd_miss_count", miss_count, mmc);
    end
    // asynchronous reset between clock edges
    h_count = 100; v_count = 100;
    cyc();
    #2 rst = 1;
    #1;
    chk("async_rst_rgb", rgb, 0);
    chk("async_rst_hit_count", hit_count, 0);
    chk("async_rst_miss_count", miss_count, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lane_note_renderer.md
Name: lane_note_renderer

Overview:
- Parametrised N-lane successor to the three-column note display; holds up to SLOTS falling notes per lane.
- On each frame tick it advances every active note, retires notes that pass the bottom, and scores button presses against a strike window.
- Renders the playfield (borders, gaps, strike line, notes) as a registered 24-bit colour per pixel.
- Sits between the VGA timing driver and the random note spawner.

Parameters:
- N_LANES, 3, number of lanes (1-8).
- SLOTS, 4, note slots per lane (power of two, 2-16).
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines.
- BORDER, 4, black margin at left/right screen edges.
- LANE_W, 208, lane width in pixels.
- GAP, 4, black gap between lanes.
- NOTE_H, 40, note height in lines.
- STRIKE_Y, 380, first line of the 4-line black strike bar.
- HIT_TOL, 16, half-width of the hit window in lines.
- LANE_COLORS, {FF0000,FFFF00,0000FF}, packed 24*N_LANES note colours; lane 0 in the LSBs.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  1 = game running; 0 = freeze.
- frame_tick  in  1  one-cycle pulse at start of vertical blank.
- speed  in  4  pixels moved per frame tick (0 = stationary).
- h_count  in  10  current pixel column.
- v_count  in  10  current pixel row.
- spawn_valid  in  1  spawn request.
- spawn_lane  in  $clog2(N_LANES)  target lane.
- spawn_ready  out  1  addressed lane has a free slot and run=1.
- btn  in  N_LANES  debounced, synchronous lane buttons (level).
- hit_pulse  out  1  one-cycle pulse on a scored hit.
- miss_pulse  out  1  one-cycle pulse on a note retired unhit, or an empty press.
- hit_count  out  16  saturating hit total.
- miss_count  out  16  saturating miss total.
- rgb  out  24  pixel colour.

Behaviour:
- Reset (async): all slots invalid, all y=0, rgb=0, counts=0, pulses=0, button-edge registers=0. Reset mid-frame clears all state immediately.
- Slot state: valid bit plus 10-bit y, where y is the note's top line.
- Lane i geometry: x0 = BORDER + i*(LANE_W+GAP); lane spans [x0, x0+LANE_W).
- Spawn:
  - Handshake completes when spawn_valid && spawn_ready.
  - Fills the lowest-index free slot of spawn_lane with y=0, valid=1.
  - spawn_ready is combinational from the current cycle's free map; slots freed this cycle are not visible to spawns until the next cycle.
  - spawn_lane >= N_LANES forces spawn_ready=0.
- Movement: on frame_tick && run, every valid slot computes y' = y + speed in 11-bit arithmetic.
  - y' >= V_ACTIVE: slot invalidated and counted as one miss.
  - Otherwise y <= y'.
- Hit detection:
  - Rising edge of btn[i] (registered previous value) while run=1.
  - Window: note bottom (y+NOTE_H) lies in [STRIKE_Y-HIT_TOL, STRIKE_Y+HIT_TOL], inclusive.
  - One or more valid slots in window: free the one with the largest y (lowest index on tie), hit_pulse=1, hit_count++.
  - No slot in window: miss_pulse=1, miss_count++.
- Simultaneous events:
  - Hit and frame_tick on the same lane: the hit is evaluated on pre-move y; the hit slot is freed and not moved.
  - Several lanes may hit, retire or miss in one cycle. Counters add the per-cycle total of hits and misses and saturate at FFFF.
  - hit_pulse and miss_pulse may assert together.
- run=0: positions frozen, spawns refused, presses ignored; the edge register still tracks btn, so releasing run never creates a false edge.
- Render:
  - rgb is registered with 1-cycle latency from h_count/v_count. All slot positions are read from current state; updates happen in blanking, so no tearing.
  - Priority: outside active area -> 0; note pixel (lowest lane, then lowest slot wins) -> lane colour; strike bar rows [STRIKE_Y, STRIKE_Y+4) -> 000000; lane interior -> FFFFFF; border/gap -> 000000.
  - A note pixel is h in lane range and v in [y, y+NOTE_H), compared in 11 bits.

Decomposition:
- Package `note_pkg`: screen constants, default lane colours, slot struct {valid, y[9:0]}, and the function lane_x0(i).
- Sub-module `lane_slots`, one per lane via generate, owns:
  - the slot array;
  - free-slot priority encoder;
  - movement and retire logic;
  - hit-window search;
  - per-lane note_pixel output.
- Top level owns spawn demux, counters, button edges and final rgb mux.

Test Plan:
1. Reset, run=1, spawn lane 1 -> spawn_ready=1. Next frame with speed=4: after 85 ticks y=340, bottom=380, in window. Press btn[1] -> hit_pulse one cycle, hit_count=1, slot freed.
2. Spawn 4 notes into lane 0 with SLOTS=4 -> spawn_ready=0 on lane 0, lanes 1/2 still ready. A 5th spawn_valid is ignored.
3. Note with speed=15 never pressed -> freed on the tick where y+15 >= 480, miss_pulse once, miss_count=1.
4. Press btn[2] with lane 2 empty -> miss_pulse, miss_count=1. Holding btn for 100 cycles produces no further pulses.
5. Note at bottom=380 in lane 0: btn[0] edge and frame_tick in the same cycle -> hit scored, slot freed, no retire miss.
6. Pixel checks with a note at y=100 in lane 0, one cycle after the stimulus:
   - h=4, v=100 -> rgb FF0000;
   - h=212 -> 000000;
   - v=381 -> 000000;
   - h=700 -> 000000.
